uart_image_receiver: RTL and testbench

//   Receive end of the UART image link. Takes bytes from the UART receiver, assembles R,G,B

---
 rtl/uart_image_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_uart_image_receiver.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_image_receiver.sv
// -----------------------------------------------------------------------------
// uart_image_receiver
//   Receive end of the UART image link. Bytes from the UART receiver are
//   grouped into R,G,B triplets, each triplet becomes one 24-bit pixel that is
//   written in raster order to a frame-buffer write port. After the last pixel
//   a 10-byte trailer 0x00..0x09 must follow; the block then reports done, or
//   frame_err with a cause code if anything went wrong on the way.
//
// Parameters
//   WIDTH, HEIGHT  frame geometry, NPIX = WIDTH*HEIGHT pixels per frame
//   ADDR_W         pixel address width, 2**ADDR_W >= NPIX
//   TIMEOUT        max clk cycles between bytes once a frame started, 0 = off
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   en             high = receive one frame, low = return to idle / abort
//   rx_data        byte from the UART receiver, valid when rx_valid
//   rx_valid       one-cycle byte strobe
//   wr_data        pixel {R,G,B}
//   wr_addr        pixel index 0..NPIX-1
//   wr_en          write request, held with data/addr until wr_ready
//   wr_ready       sink accepts in any cycle with wr_en & wr_ready
//   done           frame and trailer received correctly
//   frame_err      frame failed, err_code gives the cause
//   err_code       0 none, 1 bad trailer byte, 2 pixel overrun, 3 timeout
//   state          IDLE=0 COLLECT=1 TRAILER=2 DONE=3 ERROR=4 (debug)
// -----------------------------------------------------------------------------
module uart_image_receiver #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int ADDR_W  = 19,
   parameter int TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [23:0]       wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic              done,
   output logic              frame_err,
   output logic [1:0]        err_code,
   output logic [2:0]        state
);

   localparam int              NPIX     = WIDTH * HEIGHT;
   // pix_cnt is one bit wider than the address so it can hold NPIX itself
   localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W + 1)'(NPIX - 1);
   localparam logic [ADDR_W:0] PIX_ONE  = (ADDR_W + 1)'(1);
   localparam logic [31:0]     TMO      = 32'(TIMEOUT);
   localparam logic [3:0]      TRL_LEN  = 4'd10;

   localparam logic [1:0] ERR_TRAILER = 2'd1;
   localparam logic [1:0] ERR_OVERRUN = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      TRAILER = 3'd2,
      DONE    = 3'd3,
      ERROR   = 3'd4
   } state_t;

   state_t          st;
   logic [1:0]      byte_idx;
   logic [7:0]      r_q;
   logic [7:0]      g_q;
   logic [ADDR_W:0] pix_cnt;
   logic [3:0]      trail_idx;
   logic [31:0]     gap;
   logic            gap_run;    // gap counter armed by the first byte of a frame

   logic accept;
   logic timed_out;

   // wr_en doubles as the "write pending" flag: it is set when a pixel is
   // issued and cleared only by acceptance, abort, error or reset.
   assign accept    = wr_en & wr_ready;
   assign timed_out = (TIMEOUT != 0) && gap_run && (gap == TMO);
   assign state     = st;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st        <= IDLE;
         byte_idx  <= '0;
         r_q       <= '0;
         g_q       <= '0;
         pix_cnt   <= '0;
         trail_idx <= '0;
         gap       <= '0;
         gap_run   <= 1'b0;
         wr_en     <= 1'b0;
         wr_data   <= '0;
         wr_addr   <= '0;
         done      <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= '0;
      end else begin
         // Inter-byte gap: cleared by every byte, saturates rather than wraps
         // so a disabled timeout can idle forever without aliasing.
         if (st == COLLECT || st == TRAILER) begin
            if (rx_valid) begin
               gap     <= '0;
               gap_run <= 1'b1;
            end else if (gap_run && gap != '1) begin
               gap <= gap + 32'd1;
            end
         end

         case (st)
            IDLE: begin
               if (en) begin
                  st        <= COLLECT;
                  pix_cnt   <= '0;
                  byte_idx  <= '0;
                  trail_idx <= '0;
                  gap       <= '0;
                  gap_run   <= 1'b0;
                  done      <= 1'b0;
                  frame_err <= 1'b0;
                  err_code  <= '0;
               end
            end

            COLLECT: begin
               // Exits are checked first so a byte arriving with them is dropped.
               if (!en) begin
                  st       <= IDLE;
                  wr_en    <= 1'b0;
                  byte_idx <= '0;
               end else if (timed_out) begin
                  st        <= ERROR;
                  frame_err <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  wr_en     <= 1'b0;
               end else begin
                  if (accept)
                     wr_en <= 1'b0;
                  if (rx_valid) begin
                     if (byte_idx == 2'd0) r_q <= rx_data;
                     if (byte_idx == 2'd1) g_q <= rx_data;
                     if (byte_idx == 2'd2) begin
                        byte_idx <= '0;
                        // A write accepted this very cycle frees the slot, so
                        // only a still-stalled write counts as an overrun.
                        if (wr_en && !wr_ready) begin
                           st        <= ERROR;
                           frame_err <= 1'b1;
                           err_code  <= ERR_OVERRUN;
                           wr_en     <= 1'b0;
                        end else begin
                           wr_en   <= 1'b1;
                           wr_data <= {r_q, g_q, rx_data};
                           wr_addr <= pix_cnt[ADDR_W-1:0];
                           pix_cnt <= pix_cnt + PIX_ONE;
                           if (pix_cnt == LAST_PIX)
                              st <= TRAILER;
                        end
                     end else begin
                        byte_idx <= byte_idx + 2'd1;
                     end
                  end
               end
            end

            TRAILER: begin
               if (!en) begin
                  st    <= IDLE;
                  wr_en <= 1'b0;
               end else if (timed_out) begin
                  st        <= ERROR;
                  frame_err <= 1'b1;
                  err_code  <= ERR_TIMEOUT;
                  wr_en     <= 1'b0;
               end else if (rx_valid && trail_idx != TRL_LEN &&
                            rx_data != {4'd0, trail_idx}) begin
                  st        <= ERROR;
                  frame_err <= 1'b1;
                  err_code  <= ERR_TRAILER;
                  wr_en     <= 1'b0;
               end else begin
                  // The last pixel write may still be draining here.
                  if (accept)
                     wr_en <= 1'b0;
                  if (rx_valid && trail_idx != TRL_LEN)
                     trail_idx <= trail_idx + 4'd1;
                  if (trail_idx == TRL_LEN && !wr_en) begin
                     st   <= DONE;
                     done <= 1'b1;
                  end
               end
            end

            DONE: begin
               if (!en) begin
                  st   <= IDLE;
                  done <= 1'b0;
               end
            end

            ERROR: begin
               // frame_err/err_code are left for software to read until restart
               if (!en)
                  st <= IDLE;
            end

            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_image_receiver.sv
module tb_uart_image_receiver;
   localparam int NPIX = 8;
   localparam int AW   = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          wr_ready = 1'b0;

   logic [23:0]   wr_data, wr_data0;
   logic [AW-1:0] wr_addr, wr_addr0;
   logic          wr_en, wr_en0, done, done0, frame_err, frame_err0;
   logic [1:0]    err_code, err_code0;
   logic [2:0]    state, state0;

   int checks = 0;
   int errors = 0;
   bit rand_stop;

   // accepted writes as {addr, data}
   logic [AW+23:0] got_q[$];

   uart_image_receiver #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .TIMEOUT(50)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en), .wr_ready(wr_ready),
      .done(done), .frame_err(frame_err), .err_code(err_code), .state(state));

   uart_image_receiver #(.WIDTH(4), .HEIGHT(2), .ADDR_W(AW), .TIMEOUT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .rx_data(rx_data), .rx_valid(rx_valid),
      .wr_data(wr_data0), .wr_addr(wr_addr0), .wr_en(wr_en0), .wr_ready(wr_ready),
      .done(done0), .frame_err(frame_err0), .err_code(err_code0), .state(state0));

   always #5 clk = ~clk;

   // inputs change at posedge+1, so at negedge they are what the next edge sees
   always @(negedge clk)
      if (rst_n && wr_en && wr_ready)
         got_q.push_back({wr_addr, wr_data});

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic start_frame();
      en = 1'b0;
      tick();
      tick();
      en = 1'b1;
      tick();
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim, output bit ok);
      int c = 0;
      while (state !== s && c < lim) begin
         tick();
         c++;
      end
      ok = (state === s);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({wr_en, done, frame_err, err_code, state, wr_addr, wr_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%0h exp=0",
                  {wr_en, done, frame_err, err_code, state, wr_addr, wr_data});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (state !== 3'd0) begin errors++; $display("FAIL reset_idle got=%0d exp=0", state); end
   endtask

   task automatic test_normal();
      bit ok;
      got_q.delete();
      wr_ready = 1'b1;
      start_frame();
      for (int n = 0; n < NPIX; n++) begin
         send_byte(8'(n));
         send_byte(8'(n + 1));
         send_byte(8'(n + 2));
         if (n == 0) begin
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 3'd0) begin
               errors++;
               $display("FAIL normal_latency wr_en=%b addr=%0d exp 1/0", wr_en, wr_addr);
            end
         end
      end
      for (int t = 0; t < 10; t++) send_byte(8'(t));
      wait_state(3'd3, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL normal_done_state got=%0d exp=3", state); end
      checks++;
      if (got_q.size() != NPIX) begin
         errors++; $display("FAIL normal_count got=%0d exp=%0d", got_q.size(), NPIX);
      end
      for (int k = 0; k < NPIX && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== {3'(k), 8'(k), 8'(k + 1), 8'(k + 2)}) begin
            errors++;
            $display("FAIL normal_write%0d got=%0h exp=%0h", k, got_q[k],
                     {3'(k), 8'(k), 8'(k + 1), 8'(k + 2)});
         end
      end
      checks++;
      if ({done, frame_err, err_code} !== 4'b1000) begin
         errors++; $display("FAIL normal_flags got=%b exp=1000", {done, frame_err, err_code});
      end
      checks++;
      if (done0 !== 1'b1 || wr_addr0 !== 3'd7 || wr_data0 !== 24'h070809) begin
         errors++;
         $display("FAIL normal_dut0 done=%b addr=%0d data=%0h exp 1/7/070809",
                  done0, wr_addr0, wr_data0);
      end
      en = 1'b0;
      tick();
      checks++;
      if (state !== 3'd0 || done !== 1'b0) begin
         errors++; $display("FAIL normal_exit state=%0d done=%b exp 0/0", state, done);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      got_q.delete();
      wr_ready = 1'b0;
      start_frame();
      fork
         begin
            for (int n = 0; n < NPIX; n++)
               for (int j = 0; j < 3; j++) begin
                  send_byte(8'(n + j));
                  repeat (10) tick();
               end
            for (int t = 0; t < 10; t++) begin
               send_byte(8'(t));
               repeat (10) tick();
            end
         end
         begin
            for (int k = 0; k < NPIX; k++) begin
               int c = 0;
               logic [23:0] d;
               logic [AW-1:0] a;
               while (!wr_en && c < 400) begin tick(); c++; end
               checks++;
               if (wr_en !== 1'b1) begin errors++; $display("FAIL bp_wait%0d got=0 exp=1", k); end
               d = wr_data;
               a = wr_addr;
               repeat (3) begin
                  tick();
                  checks++;
                  if (wr_en !== 1'b1 || wr_data !== d || wr_addr !== a) begin
                     errors++;
                     $display("FAIL bp_stable%0d got=%b/%0h/%0d exp=1/%0h/%0d",
                              k, wr_en, wr_data, wr_addr, d, a);
                  end
               end
               wr_ready = 1'b1;
               tick();
               wr_ready = 1'b0;
            end
         end
      join
      wait_state(3'd3, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_done got=%0d exp=3", state); end
      checks++;
      if (got_q.size() != NPIX) begin
         errors++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), NPIX);
      end
      for (int k = 0; k < NPIX && k < got_q.size(); k++) begin
         checks++;
         if (got_q[k] !== {3'(k), 8'(k), 8'(k + 1), 8'(k + 2)}) begin
            errors++; $display("FAIL bp_write%0d got=%0h", k, got_q[k]);
         end
      end
   endtask

   task automatic test_bad_trailer();
      wr_ready = 1'b1;
      start_frame();
      for (int i = 0; i < 3 * NPIX; i++) send_byte(8'($urandom));
      send_byte(8'd0);
      send_byte(8'd1);
      send_byte(8'd2);
      checks++;
      if (state !== 3'd2) begin errors++; $display("FAIL trl_mid got=%0d exp=2", state); end
      send_byte(8'd7);
      checks++;
      if ({state, frame_err, err_code, done} !== {3'd4, 1'b1, 2'd1, 1'b0}) begin
         errors++;
         $display("FAIL trl_err got=%0d/%b/%0d/%b exp=4/1/1/0", state, frame_err, err_code, done);
      end
      en = 1'b0;
      tick();
      checks++;
      if ({state, frame_err, err_code} !== {3'd0, 1'b1, 2'd1}) begin
         errors++;
         $display("FAIL trl_hold got=%0d/%b/%0d exp=0/1/1", state, frame_err, err_code);
      end
   endtask

   task automatic test_overrun();
      got_q.delete();
      wr_ready = 1'b0;
      start_frame();
      for (int i = 0; i < 6; i++) send_byte(8'($urandom));
      checks++;
      if ({state, frame_err, err_code, wr_en} !== {3'd4, 1'b1, 2'd2, 1'b0}) begin
         errors++;
         $display("FAIL ovr_err got=%0d/%b/%0d/%b exp=4/1/2/0", state, frame_err, err_code, wr_en);
      end
      wr_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (got_q.size() != 0) begin errors++; $display("FAIL ovr_writes got=%0d exp=0", got_q.size()); end
   endtask

   task automatic test_timeout();
      int k = 0;
      wr_ready = 1'b1;
      start_frame();
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      repeat (45) begin tick(); k++; end
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL tmo_early got=%0d exp=1", state); end
      while (state !== 3'd4 && k < 70) begin tick(); k++; end
      checks++;
      if (state !== 3'd4 || err_code !== 2'd3 || frame_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_err got=%0d/%0d/%b exp=4/3/1", state, err_code, frame_err);
      end
      while (k < 1000) begin tick(); k++; end
      checks++;
      if ({state0, frame_err0, err_code0, wr_en0} !== {3'd1, 1'b0, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL tmo_off got=%0d/%b/%0d/%b exp=1/0/0/0", state0, frame_err0, err_code0, wr_en0);
      end
   endtask

   task automatic test_abort_reset();
      logic [7:0] c0, c1, c2;
      got_q.delete();
      wr_ready = 1'b1;
      start_frame();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      en = 1'b0;
      tick();
      checks++;
      if (state !== 3'd0 || wr_en !== 1'b0) begin
         errors++; $display("FAIL abort_idle got=%0d/%b exp=0/0", state, wr_en);
      end
      repeat (5) tick();
      checks++;
      if (got_q.size() != 1 || done !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL abort_quiet got=%0d/%b/%b exp=1/0/0", got_q.size(), done, frame_err);
      end
      start_frame();
      c0 = 8'($urandom); c1 = 8'($urandom); c2 = 8'($urandom);
      send_byte(c0); send_byte(c1); send_byte(c2);
      repeat (2) tick();
      checks++;
      if (got_q.size() != 2 || got_q[got_q.size() - 1] !== {3'd0, c0, c1, c2}) begin
         errors++;
         $display("FAIL restart_addr0 got=%0h exp=%0h", got_q[got_q.size() - 1], {3'd0, c0, c1, c2});
      end
      wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(8'($urandom));
      checks++;
      if (wr_en !== 1'b1) begin errors++; $display("FAIL rst_pending got=%b exp=1", wr_en); end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({wr_en, done, frame_err, err_code, state, wr_addr, wr_data} !== '0) begin
         errors++;
         $display("FAIL rst_mid got=%0h exp=0", {wr_en, done, frame_err, err_code, state, wr_addr, wr_data});
      end
      rst_n = 1'b1;
      wr_ready = 1'b1;
      repeat (5) tick();
      checks++;
      if (got_q.size() != 2) begin errors++; $display("FAIL rst_writes got=%0d exp=2", got_q.size()); end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 3; f++) begin
         logic [7:0] b[$];
         bit ok;
         got_q.delete();
         b.delete();
         for (int i = 0; i < 3 * NPIX; i++) b.push_back(8'($urandom));
         wr_ready = 1'b1;
         start_frame();
         rand_stop = 1'b0;
         fork
            begin
               foreach (b[i]) begin
                  send_byte(b[i]);
                  repeat ($urandom_range(1, 3)) tick();
               end
               for (int t = 0; t < 10; t++) begin
                  send_byte(8'(t));
                  repeat ($urandom_range(0, 3)) tick();
               end
               wait_state(3'd3, 40, ok);
               rand_stop = 1'b1;
            end
            begin
               int low = 0;
               while (!rand_stop) begin
                  tick();
                  if (rand_stop) break;
                  wr_ready = (low >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                  low = wr_ready ? 0 : low + 1;
               end
            end
         join
         wr_ready = 1'b1;
         checks++;
         if (!ok || done !== 1'b1) begin
            errors++; $display("FAIL rnd%0d_done got=%0d/%b exp=3/1", f, state, done);
         end
         checks++;
         if (got_q.size() != NPIX) begin
            errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", f, got_q.size(), NPIX);
         end
         for (int k = 0; k < NPIX && k < got_q.size(); k++) begin
            checks++;
            if (got_q[k] !== {3'(k), b[3*k], b[3*k+1], b[3*k+2]}) begin
               errors++;
               $display("FAIL rnd%0d_write%0d got=%0h exp=%0h", f, k, got_q[k],
                        {3'(k), b[3*k], b[3*k+1], b[3*k+2]});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_backpressure();
      test_bad_trailer();
      test_overrun();
      test_timeout();
      test_abort_reset();
      test_random_frames();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
